// File: rtl/miner_work_sequencer_pkg.sv
// Shared network packet definitions plus the mining command words and barrier constants
// used by the hardware mining sequencer.
package miner_work_sequencer_pkg;

    localparam int mask_length_gp = 3;

    typedef enum logic [2:0] {
        NULL  = 3'd0,
        INSTR = 3'd1,
        REG   = 3'd2,
        PC    = 3'd3,
        BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [5:0]  reserved;
        logic [9:0]  ID;
        net_op_e     net_op;
        logic [9:0]  addr;
        logic [31:0] data;
    } net_packet_s;

    // Command words written into the core's command register
    typedef enum logic [31:0] {
        LDWORK  = 32'd1,
        LDNONCE = 32'd2,
        DONE    = 32'd3
    } miner_cmd_e;

    localparam logic [31:0] bar_mask_init_gp = 32'd7;
    localparam logic [9:0]  bar_mask_addr_gp = 10'd24;

endpackage

// File: rtl/miner_work_sequencer_if.sv
// Job, result and core-facing signals of the mining sequencer; the sequencer uses the
// slave modport, the job source / core side uses master.
interface miner_work_sequencer_if;
    import miner_work_sequencer_pkg::*;

    logic                               job_valid_i;
    logic                               job_ready_o;
    logic [7:0][31:0]                   midstate_i;
    logic [2:0][31:0]                   work_i;
    logic [31:0]                        nonce_start_i;
    logic [31:0]                        nonce_end_i;
    logic [mask_length_gp-1:0]          barrier_i;
    logic                               exception_i;
    logic [$bits(net_packet_s)-1:0]     net_packet_flat_o;
    logic                               result_valid_o;
    logic                               result_yumi_i;
    logic                               result_found_o;
    logic                               result_error_o;
    logic [31:0]                        result_nonce_o;

    modport slave (
        input  job_valid_i, midstate_i, work_i, nonce_start_i, nonce_end_i,
        input  barrier_i, exception_i, result_yumi_i,
        output job_ready_o, net_packet_flat_o, result_valid_o,
        output result_found_o, result_error_o, result_nonce_o
    );

    modport master (
        output job_valid_i, midstate_i, work_i, nonce_start_i, nonce_end_i,
        output barrier_i, exception_i, result_yumi_i,
        input  job_ready_o, net_packet_flat_o, result_valid_o,
        input  result_found_o, result_error_o, result_nonce_o
    );

endinterface

// File: rtl/miner_pkt_builder.sv
// Combinational packet assembly: stamps the core ID and clears the reserved field.
module miner_pkt_builder
    import miner_work_sequencer_pkg::*;
#(
    parameter logic [9:0] core_id_p = 10'd1
) (
    input  net_op_e     op,
    input  logic [9:0]  addr,
    input  logic [31:0] data,
    output net_packet_s pkt
);

    always_comb begin
        pkt          = '0;
        pkt.reserved = '0;
        pkt.ID       = core_id_p;
        pkt.net_op   = op;
        pkt.addr     = addr;
        pkt.data     = data;
    end

endmodule

// File: rtl/miner_work_sequencer.sv
// Loads one mining job into the core, walks the nonce range through REG/PC packets while
// polling the core barrier, and reports found / exhausted / error.
module miner_work_sequencer
    import miner_work_sequencer_pkg::*;
#(
    parameter logic [9:0] core_id_p       = 10'd1,
    parameter int         settle_cycles_p = 4,
    parameter logic [9:0] cmd_addr_p      = 10'd20,
    parameter logic [9:0] nonce_addr_p    = 10'd1
) (
    input logic                   clk,
    input logic                   reset,
    miner_work_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_WAIT, S_GAP, S_ISSUE, S_FOUND, S_RESULT
    } state_e;

    typedef enum logic { PH_LDWORK, PH_NONCE } phase_e;

    localparam logic [7:0] settle_last_lp = 8'(settle_cycles_p - 1);
    localparam logic [7:0] load_last_lp   = 8'd14;
    localparam logic [mask_length_gp-1:0] barrier_found_lp = mask_length_gp'(1);
    localparam logic [mask_length_gp-1:0] barrier_clear_lp = '0;

    state_e      state_reg, state_next;
    phase_e      phase_reg, phase_next;
    logic [7:0]  step_reg, step_next;
    logic [31:0] nonce_reg, nonce_next;
    logic [31:0] nonce_end_reg;
    logic        found_reg, found_next;
    logic        error_reg, error_next;
    logic [31:0] rnonce_reg, rnonce_next;
    logic [31:0] midstate_reg [8];
    logic [31:0] work_reg [3];

    logic        accept;
    net_op_e     op;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [2:0]  ms_idx;
    logic [1:0]  wk_idx;
    net_packet_s pkt_comb, pkt_reg;

    assign accept = bus.job_valid_i && (state_reg == S_IDLE);
    assign ms_idx = 3'(step_reg - 8'd1);
    assign wk_idx = 2'(step_reg - 8'd9);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_midstate
            always_ff @(posedge clk) begin
                if (accept) midstate_reg[gi] <= bus.midstate_i[gi];
            end
        end
        for (genvar gi = 0; gi < 3; gi++) begin : g_work
            always_ff @(posedge clk) begin
                if (accept) work_reg[gi] <= bus.work_i[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            phase_reg     <= PH_LDWORK;
            step_reg      <= '0;
            nonce_reg     <= '0;
            nonce_end_reg <= '0;
            found_reg     <= 1'b0;
            error_reg     <= 1'b0;
            rnonce_reg    <= '0;
            pkt_reg       <= '0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            step_reg   <= step_next;
            nonce_reg  <= nonce_next;
            found_reg  <= found_next;
            error_reg  <= error_next;
            rnonce_reg <= rnonce_next;
            pkt_reg    <= pkt_comb;
            if (accept) nonce_end_reg <= bus.nonce_end_i;
        end
    end

    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        step_next   = step_reg;
        nonce_next  = nonce_reg;
        found_next  = found_reg;
        error_next  = error_reg;
        rnonce_next = rnonce_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_LOAD;
                    step_next  = '0;
                    phase_next = PH_LDWORK;
                    nonce_next = bus.nonce_start_i;
                end
            end
            S_LOAD: begin
                if (step_reg == load_last_lp) begin
                    state_next = S_SETTLE;
                    step_next  = '0;
                end else begin
                    step_next = step_reg + 8'd1;
                end
            end
            S_SETTLE: begin
                if (step_reg == settle_last_lp) begin
                    state_next = S_WAIT;
                    step_next  = '0;
                end else begin
                    step_next = step_reg + 8'd1;
                end
            end
            S_WAIT: begin
                // Exception outranks a found barrier seen in the same cycle
                if (bus.exception_i) begin
                    state_next  = S_RESULT;
                    found_next  = 1'b0;
                    error_next  = 1'b1;
                    rnonce_next = nonce_reg;
                end else if (bus.barrier_i == barrier_found_lp) begin
                    state_next = S_FOUND;
                    step_next  = '0;
                end else if (bus.barrier_i == barrier_clear_lp) begin
                    if (phase_reg == PH_LDWORK) begin
                        state_next = S_GAP;
                        step_next  = '0;
                    end else if (nonce_reg == nonce_end_reg) begin
                        state_next  = S_RESULT;
                        found_next  = 1'b0;
                        error_next  = 1'b0;
                        rnonce_next = nonce_reg;
                    end else begin
                        nonce_next = nonce_reg + 32'd1;
                        state_next = S_GAP;
                        step_next  = '0;
                    end
                end
            end
            S_GAP: begin
                if (step_reg == 8'd1) begin
                    state_next = S_ISSUE;
                    step_next  = '0;
                end else begin
                    step_next = step_reg + 8'd1;
                end
            end
            S_ISSUE: begin
                if (step_reg == 8'd3) begin
                    state_next = S_SETTLE;
                    step_next  = '0;
                    phase_next = PH_NONCE;
                end else begin
                    step_next = step_reg + 8'd1;
                end
            end
            S_FOUND: begin
                if (step_reg == 8'd4) begin
                    state_next  = S_RESULT;
                    found_next  = 1'b1;
                    error_next  = 1'b0;
                    rnonce_next = nonce_reg;
                end else begin
                    step_next = step_reg + 8'd1;
                end
            end
            S_RESULT: begin
                if (bus.result_yumi_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        op   = NULL;
        addr = '0;
        data = '0;
        unique case (state_reg)
            S_LOAD: begin
                if (step_reg == 8'd0) begin
                    op   = BAR;
                    addr = bar_mask_addr_gp;
                    data = bar_mask_init_gp;
                end else if (step_reg <= 8'd8) begin
                    op   = REG;
                    addr = 10'(step_reg);
                    data = midstate_reg[ms_idx];
                end else if (step_reg <= 8'd11) begin
                    op   = REG;
                    addr = 10'(step_reg);
                    data = work_reg[wk_idx];
                end else if (step_reg == 8'd12) begin
                    op   = REG;
                    addr = cmd_addr_p;
                    data = 32'(LDWORK);
                end else if (step_reg == 8'd13) begin
                    op   = PC;
                    data = 32'd2;
                end else begin
                    // Closing NULL re-arms the barrier mask register
                    addr = bar_mask_addr_gp;
                    data = 32'hFFFF_FFFE;
                end
            end
            S_ISSUE: begin
                if (step_reg == 8'd0) begin
                    op   = REG;
                    addr = nonce_addr_p;
                    data = nonce_reg;
                end else if (step_reg == 8'd1) begin
                    op   = REG;
                    addr = cmd_addr_p;
                    data = 32'(LDNONCE);
                end else if (step_reg == 8'd2) begin
                    op   = PC;
                    data = 32'd2;
                end
            end
            S_FOUND: begin
                if (step_reg == 8'd2) begin
                    op   = REG;
                    addr = cmd_addr_p;
                    data = 32'(DONE);
                end else if (step_reg == 8'd3) begin
                    op   = PC;
                    data = 32'd2;
                end
            end
            default: begin
                op   = NULL;
                addr = '0;
                data = '0;
            end
        endcase
    end

    miner_pkt_builder #(.core_id_p(core_id_p)) u_pkt_builder (
        .op   (op),
        .addr (addr),
        .data (data),
        .pkt  (pkt_comb)
    );

    assign bus.net_packet_flat_o = pkt_reg;
    assign bus.job_ready_o       = (state_reg == S_IDLE);
    assign bus.result_valid_o    = (state_reg == S_RESULT);
    assign bus.result_found_o    = found_reg;
    assign bus.result_error_o    = error_reg;
    assign bus.result_nonce_o    = rnonce_reg;

endmodule

// File: tb/tb_miner_work_sequencer.sv
// Bench for miner_work_sequencer: a small core model answers barrier/exception, and the
// emitted packet stream plus result fields are compared with a job-level reference model.
module tb_miner_work_sequencer;
    import miner_work_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    miner_work_sequencer_if bus ();

    miner_work_sequencer #(
        .core_id_p       (10'd1),
        .settle_cycles_p (4),
        .cmd_addr_p      (10'd20),
        .nonce_addr_p    (10'd1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0][31:0] ms;
        logic [2:0][31:0] wk;
        logic [31:0]      start;
        logic [31:0]      stop;
        bit               tgt_en;
        logic [31:0]      tgt;
        bit               exc_en;
        logic [31:0]      exc;
    } job_t;

    typedef struct {
        logic [31:0] start;
        logic [31:0] stop;
        bit          tgt_en;
        logic [31:0] tgt;
        bit          exc_en;
        logic [31:0] exc;
        int          hold;
        bit          exp_found;
        bit          exp_error;
        logic [31:0] exp_nonce;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    net_packet_s got_q[$];
    int          got_t[$];
    net_packet_s exp_q[$];

    bit          tgt_en, exc_en, busy_en, nonce_seen;
    logic [31:0] tgt, exc_nonce, last_nonce;
    int          pc_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic net_packet_s mk(net_op_e op, logic [9:0] a, logic [31:0] d);
        net_packet_s p;
        p        = '0;
        p.ID     = 10'd1;
        p.net_op = op;
        p.addr   = a;
        p.data   = d;
        return p;
    endfunction

    // Core model plus packet monitor: records every non-idle packet and answers the
    // barrier according to the most recently issued nonce.
    always @(negedge clk) begin
        net_packet_s p;
        cyc++;
        if (!reset) begin
            p = net_packet_s'(bus.net_packet_flat_o);
            if (p.net_op != NULL || p.addr != '0 || p.data != '0) begin
                got_q.push_back(p);
                got_t.push_back(cyc);
            end
            if (p.net_op == PC) pc_count++;
            if (p.net_op == REG && p.addr == 10'd1 && pc_count > 0) begin
                last_nonce = p.data;
                nonce_seen = 1'b1;
            end
        end
        if (busy_en && $urandom_range(0, 3) == 0)
            bus.barrier_i = 3'b010;
        else if (tgt_en && nonce_seen && last_nonce == tgt)
            bus.barrier_i = 3'b001;
        else
            bus.barrier_i = 3'b000;
        bus.exception_i = exc_en && nonce_seen && (last_nonce == exc_nonce);
    end

    // Expected packet stream and result for a whole job, walking the nonce range
    task automatic build_expected(input job_t j, output bit f, output bit e, output logic [31:0] n);
        logic [31:0] cur;
        cur = j.start;
        f = 1'b0; e = 1'b0; n = cur;
        exp_q.delete();
        exp_q.push_back(mk(BAR, 10'd24, 32'd7));
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(REG, 10'(k + 1), j.ms[k]));
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(REG, 10'(k + 9), j.wk[k]));
        exp_q.push_back(mk(REG, 10'd20, 32'd1));
        exp_q.push_back(mk(PC, 10'd0, 32'd2));
        exp_q.push_back(mk(NULL, 10'd24, 32'hFFFF_FFFE));
        for (int it = 0; it < 64; it++) begin
            exp_q.push_back(mk(REG, 10'd1, cur));
            exp_q.push_back(mk(REG, 10'd20, 32'd2));
            exp_q.push_back(mk(PC, 10'd0, 32'd2));
            n = cur;
            if (j.exc_en && cur == j.exc) begin e = 1'b1; return; end
            if (j.tgt_en && cur == j.tgt) begin
                exp_q.push_back(mk(REG, 10'd20, 32'd3));
                exp_q.push_back(mk(PC, 10'd0, 32'd2));
                f = 1'b1;
                return;
            end
            if (cur == j.stop) return;
            cur = cur + 32'd1;
        end
    endtask

    task automatic drive_job(input job_t j);
        for (int k = 0; k < 8; k++) bus.midstate_i[k] = j.ms[k];
        for (int k = 0; k < 3; k++) bus.work_i[k] = j.wk[k];
        bus.nonce_start_i = j.start;
        bus.nonce_end_i   = j.stop;
    endtask

    task automatic run_job(input job_t j, input int hold, input bit busy, input bit use_tab,
                           input bit xf, input bit xe, input logic [31:0] xn, input string tag);
        bit mf, me, rf, re;
        logic [31:0] mn, rn;
        int waited;
        build_expected(j, mf, me, mn);
        if (use_tab) begin rf = xf; re = xe; rn = xn; end
        else         begin rf = mf; re = me; rn = mn; end
        @(negedge clk);
        tgt_en = j.tgt_en; tgt = j.tgt; exc_en = j.exc_en; exc_nonce = j.exc;
        busy_en = busy; nonce_seen = 1'b0; pc_count = 0;
        got_q.delete(); got_t.delete();
        chk({tag, "_ready_idle"}, 64'(bus.job_ready_o), 64'd1);
        drive_job(j);
        bus.job_valid_i = 1'b1;
        @(negedge clk);
        bus.job_valid_i = 1'b0;
        waited = 0;
        while (!bus.result_valid_o && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.result_valid_o) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: actual no result after %0d cycles required result_valid", tag, waited);
        end
        chk({tag, "_found"}, 64'(bus.result_found_o), 64'(rf));
        chk({tag, "_error"}, 64'(bus.result_error_o), 64'(re));
        chk({tag, "_nonce"}, 64'(bus.result_nonce_o), 64'(rn));
        for (int h = 0; h < hold; h++) begin
            bus.job_valid_i = 1'b1;
            @(negedge clk);
            chk($sformatf("%s_hold%0d_ready", tag, h), 64'(bus.job_ready_o), 64'd0);
            chk($sformatf("%s_hold%0d_valid", tag, h), 64'(bus.result_valid_o), 64'd1);
            chk($sformatf("%s_hold%0d_nonce", tag, h), 64'(bus.result_nonce_o), 64'(rn));
            chk($sformatf("%s_hold%0d_found", tag, h), 64'(bus.result_found_o), 64'(rf));
        end
        bus.job_valid_i   = 1'b0;
        bus.result_yumi_i = 1'b1;
        @(negedge clk);
        bus.result_yumi_i = 1'b0;
        chk({tag, "_valid_drop"}, 64'(bus.result_valid_o), 64'd0);
        chk({tag, "_ready_back"}, 64'(bus.job_ready_o), 64'd1);
        chk({tag, "_pkt_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_pkt%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        // Without stalls, PC -> NULL -> 4 settle -> 1 wait -> 2 gap -> next nonce REG
        if (!busy) begin
            for (int i = 0; i + 1 < got_q.size(); i++)
                if (got_q[i].net_op == PC && got_q[i + 1].net_op == REG && got_q[i + 1].addr == 10'd1)
                    chk($sformatf("%s_pc_to_nonce_gap%0d", tag, i), 64'(got_t[i + 1] - got_t[i]), 64'd9);
        end
    endtask

    vec_t vecs[7];
    job_t base_job;
    job_t j;
    int   waited;

    initial begin
        reset = 1'b1;
        bus.job_valid_i = 1'b0; bus.result_yumi_i = 1'b0;
        bus.midstate_i = '0; bus.work_i = '0; bus.nonce_start_i = '0; bus.nonce_end_i = '0;
        tgt_en = 0; exc_en = 0; busy_en = 0; nonce_seen = 0; pc_count = 0;
        tgt = '0; exc_nonce = '0; last_nonce = '0;

        base_job.ms[0] = 32'h56f6950a; base_job.ms[1] = 32'h0f5ec3e6;
        base_job.ms[2] = 32'h3d1cc3ee; base_job.ms[3] = 32'h7a3d7c41;
        base_job.ms[4] = 32'h9b8e7dcb; base_job.ms[5] = 32'h2b0f3e75;
        base_job.ms[6] = 32'hd1bb8f4c; base_job.ms[7] = 32'hc01823e1;
        base_job.wk[0] = 32'ha24c2683; base_job.wk[1] = 32'hcf1beb52; base_job.wk[2] = 32'h2cf50119;
        base_job.start = '0; base_job.stop = '0;
        base_job.tgt_en = 0; base_job.tgt = '0; base_job.exc_en = 0; base_job.exc = '0;

        //          start          stop           tgt_en tgt    exc_en exc    hold found err nonce
        vecs[0] = '{32'd0,         32'd0,         0,     32'd0, 0,     32'd0, 2,   0,    0,  32'd0};
        vecs[1] = '{32'd0,         32'd5,         1,     32'd1, 0,     32'd0, 10,  1,    0,  32'd1};
        vecs[2] = '{32'hFFFF_FFFE, 32'd1,         0,     32'd0, 0,     32'd0, 1,   0,    0,  32'd1};
        vecs[3] = '{32'd0,         32'd9,         0,     32'd0, 1,     32'd3, 1,   0,    1,  32'd3};
        vecs[4] = '{32'd7,         32'd7,         0,     32'd0, 0,     32'd0, 0,   0,    0,  32'd7};
        vecs[5] = '{32'd0,         32'd9,         1,     32'd2, 1,     32'd2, 3,   0,    1,  32'd2};
        vecs[6] = '{32'd10,        32'd20,        1,     32'd10, 0,    32'd0, 0,   1,    0,  32'd10};

        repeat (3) @(negedge clk);
        chk("reset_pkt",   64'(bus.net_packet_flat_o), 64'd0);
        chk("reset_ready", 64'(bus.job_ready_o), 64'd1);
        chk("reset_valid", 64'(bus.result_valid_o), 64'd0);
        chk("reset_found", 64'(bus.result_found_o), 64'd0);
        chk("reset_error", 64'(bus.result_error_o), 64'd0);
        chk("reset_nonce", 64'(bus.result_nonce_o), 64'd0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            j = base_job;
            j.start = vecs[v].start; j.stop = vecs[v].stop;
            j.tgt_en = vecs[v].tgt_en; j.tgt = vecs[v].tgt;
            j.exc_en = vecs[v].exc_en; j.exc = vecs[v].exc;
            run_job(j, vecs[v].hold, 1'b0, 1'b1, vecs[v].exp_found, vecs[v].exp_error,
                    vecs[v].exp_nonce, $sformatf("vec%0d", v));
        end

        // Reset in the middle of the load sequence, after five packets
        @(negedge clk);
        j = base_job; j.stop = 32'd3;
        tgt_en = 0; exc_en = 0; busy_en = 0; nonce_seen = 0; pc_count = 0;
        got_q.delete(); got_t.delete();
        drive_job(j);
        bus.job_valid_i = 1'b1;
        @(negedge clk);
        bus.job_valid_i = 1'b0;
        waited = 0;
        while (got_q.size() < 5 && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("midload_pkts_before_reset", 64'(got_q.size()), 64'd5);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midload_reset_pkt",   64'(bus.net_packet_flat_o), 64'd0);
        chk("midload_reset_ready", 64'(bus.job_ready_o), 64'd1);
        chk("midload_reset_valid", 64'(bus.result_valid_o), 64'd0);
        reset = 1'b0;
        j = base_job;
        run_job(j, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, "restart");

        for (int r = 0; r < 15; r++) begin
            j = base_job;
            for (int k = 0; k < 8; k++) j.ms[k] = $urandom;
            for (int k = 0; k < 3; k++) j.wk[k] = $urandom;
            j.start  = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
            j.stop   = j.start + 32'($urandom_range(0, 6));
            j.tgt_en = ($urandom_range(0, 1) == 1);
            j.tgt    = j.start + 32'($urandom_range(0, 8));
            j.exc_en = ($urandom_range(0, 3) == 0);
            j.exc    = j.start + 32'($urandom_range(0, 8));
            run_job(j, int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,
                    $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
